// File: rtl/prescaled_event_counter.sv
// Programmable prescaler producing a one-cycle tick enable, feeding an up/down
// modulo event counter that runs continuously or as a one-shot.
module prescaled_event_counter #(
  parameter int          PRESCALE_W  = 26,
  parameter int          COUNT_W     = 4,
  parameter int unsigned DIV_DEFAULT = 33554431
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] div_value_i,
  input  logic                  div_load_i,
  input  logic                  up_down_i,
  input  logic                  mode_oneshot_i,
  input  logic [COUNT_W-1:0]    limit_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  output logic                  tick_o,
  output logic [COUNT_W-1:0]    count_o,
  output logic                  terminal_o,
  output logic                  busy_o,
  output logic                  clk_div_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [PRESCALE_W-1:0] DIV_RST = PRESCALE_W'(DIV_DEFAULT);

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   pre_q, pre_d;
  logic [PRESCALE_W-1:0]   div_q, div_d;
  logic                    mode_q, mode_d;
  logic                    tick_q, tick_d;
  logic [COUNT_W-1:0]      count_q, count_d;
  logic                    term_q, term_d;
  logic                    busy_q, busy_d;
  logic                    clk_div_q, clk_div_d;
  logic                    tick_int;
  logic [COUNT_W-1:0]      step_cnt;
  logic                    step_wrap;

  // Clear and div_load both restart the prescaler, so neither may fire a tick.
  assign tick_int = enable_i & (pre_q == div_q) & ~clear_i & ~div_load_i;

  // Next count value if a tick lands while running.
  always_comb begin
    step_cnt  = count_q;
    step_wrap = 1'b0;
    if (up_down_i) begin
      if (count_q >= limit_i) begin
        step_cnt  = '0;
        step_wrap = 1'b1;
      end else begin
        step_cnt = count_q + COUNT_W'(1);
      end
    end else if (count_q == '0) begin
      step_cnt  = limit_i;
      step_wrap = 1'b1;
    end else if (count_q > limit_i) begin
      step_cnt = limit_i;
    end else begin
      step_cnt = count_q - COUNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    div_d     = div_q;
    mode_d    = mode_q;
    tick_d    = 1'b0;
    count_d   = count_q;
    term_d    = 1'b0;
    clk_div_d = clk_div_q;
    if (clear_i) begin
      pre_d   = '0;
      state_d = IDLE;
      count_d = up_down_i ? '0 : limit_i;
    end else begin
      if (div_load_i) begin
        div_d = div_value_i;
        pre_d = '0;
      end else if (tick_int) begin
        pre_d = '0;
      end else if (enable_i) begin
        pre_d = pre_q + PRESCALE_W'(1);
      end
      tick_d = tick_int;
      if (tick_int) clk_div_d = ~clk_div_q;
      case (state_q)
        IDLE: begin
          if (!mode_oneshot_i && enable_i) begin
            state_d = RUN;
            mode_d  = 1'b0;
          end else if (mode_oneshot_i && start_i) begin
            state_d = RUN;
            mode_d  = 1'b1;
          end
        end
        RUN: begin
          if (tick_int) begin
            count_d = step_cnt;
            term_d  = step_wrap;
          end
          if (!mode_q && !enable_i) state_d = IDLE;
          else if (mode_q && tick_int && step_wrap) state_d = DONE;
        end
        DONE: begin
          if (start_i) begin
            state_d = RUN;
            count_d = up_down_i ? '0 : limit_i;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      div_q     <= DIV_RST;
      mode_q    <= 1'b0;
      tick_q    <= 1'b0;
      count_q   <= '0;
      term_q    <= 1'b0;
      busy_q    <= 1'b0;
      clk_div_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      count_q   <= count_d;
      term_q    <= term_d;
      busy_q    <= busy_d;
      clk_div_q <= clk_div_d;
    end
  end

  assign tick_o     = tick_q;
  assign count_o    = count_q;
  assign terminal_o = term_q;
  assign busy_o     = busy_q;
  assign clk_div_o  = clk_div_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_prescaled_event_counter.sv
// Directed bench for prescaled_event_counter: a per-cycle vector table for the
// one-shot paths and hand-written sequences for prescaler timing corners.
module tb_prescaled_event_counter;

  logic       clk = 1'b0;
  logic       reset, enable, div_load, up_down, mode_oneshot, start, clear;
  logic [7:0] div_value;
  logic [3:0] limit;
  logic       tick, terminal, busy, clk_div;
  logic [3:0] count;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;
  int n;
  logic [3:0] exp_q[$];

  typedef struct {
    logic       ld, st, clr, ud;
    logic [3:0] lim;
    logic       e_tick;
    logic [3:0] e_cnt;
    logic       e_term, e_busy, e_cd;
  } vec_t;
  vec_t vecs[$];

  prescaled_event_counter #(.PRESCALE_W(8), .COUNT_W(4), .DIV_DEFAULT(3)) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .div_value_i(div_value),
    .div_load_i(div_load), .up_down_i(up_down), .mode_oneshot_i(mode_oneshot),
    .limit_i(limit), .start_i(start), .clear_i(clear), .tick_o(tick),
    .count_o(count), .terminal_o(terminal), .busy_o(busy), .clk_div_o(clk_div),
    .state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Steps until tick is seen (bounded); gap is returned for the caller to check.
  task automatic wait_tick(output int gap);
    gap = 0;
    do begin
      step();
      gap++;
      if (!tick) chk("term_without_tick", terminal, 0);
    end while (!tick && gap < 64);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic add_vec(input logic ld, st, clr, ud, input logic [3:0] lim,
                         input logic e_tick, input logic [3:0] e_cnt,
                         input logic e_term, e_busy, e_cd);
    vec_t v;
    v.ld = ld; v.st = st; v.clr = clr; v.ud = ud; v.lim = lim;
    v.e_tick = e_tick; v.e_cnt = e_cnt; v.e_term = e_term; v.e_busy = e_busy; v.e_cd = e_cd;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; div_load = 1'b0; div_value = 8'd0; up_down = 1'b1;
    mode_oneshot = 1'b0; limit = 4'd9; start = 1'b0; clear = 1'b0;

    // reset values
    step();
    step();
    chk("rst_tick", tick, 0);
    chk("rst_count", count, 0);
    chk("rst_term", terminal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clk_div", clk_div, 0);

    // continuous up, then continuous down
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) exp_q.push_back(4'(k % 10));
    for (int k = 1; k <= 10; k++) begin
      wait_tick(n);
      chk($sformatf("up_gap%0d", k), n, 4);
      chk($sformatf("up_cnt%0d", k), count, exp_q.pop_front());
      chk($sformatf("up_term%0d", k), terminal, (k == 10));
      chk($sformatf("up_cd%0d", k), clk_div, k % 2);
      chk($sformatf("up_busy%0d", k), busy, 1);
    end
    up_down = 1'b0;
    limit = 4'd5;
    exp_q = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};
    for (int k = 11; k <= 17; k++) begin
      wait_tick(n);
      chk($sformatf("dn_gap%0d", k), n, 4);
      chk($sformatf("dn_cnt%0d", k), count, exp_q.pop_front());
      chk($sformatf("dn_term%0d", k), terminal, (k == 11 || k == 17));
      chk($sformatf("dn_cd%0d", k), clk_div, k % 2);
    end
    enable = 1'b0;
    step();
    chk("dis_busy", busy, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("dis_tick", tick, 0);
      chk("dis_count", count, 5);
    end

    // one-shot vector table (div reloaded to 0 so every cycle ticks)
    do_reset();
    add_vec(1, 0, 0, 1, 3,  0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 1, 3,  1, 0, 0, 0, 1);
    add_vec(0, 1, 0, 1, 3,  1, 0, 0, 1, 0);
    add_vec(0, 0, 0, 1, 3,  1, 1, 0, 1, 1);
    add_vec(0, 0, 0, 1, 3,  1, 2, 0, 1, 0);
    add_vec(0, 0, 0, 1, 3,  1, 3, 0, 1, 1);
    add_vec(0, 0, 0, 1, 3,  1, 0, 1, 0, 0);
    for (int k = 1; k <= 10; k++) add_vec(0, 0, 0, 1, 3, 1, 0, 0, 0, 1'(k % 2));
    add_vec(0, 1, 0, 1, 3,  1, 0, 0, 1, 1);
    add_vec(0, 0, 0, 1, 3,  1, 1, 0, 1, 0);
    add_vec(0, 1, 0, 1, 3,  1, 2, 0, 1, 1);
    add_vec(0, 0, 0, 1, 3,  1, 3, 0, 1, 0);
    add_vec(0, 0, 0, 1, 3,  1, 0, 1, 0, 1);
    add_vec(0, 0, 1, 0, 3,  0, 3, 0, 0, 1);
    add_vec(0, 0, 0, 0, 3,  1, 3, 0, 0, 0);
    add_vec(0, 1, 0, 0, 3,  1, 3, 0, 1, 1);
    add_vec(0, 0, 0, 0, 3,  1, 2, 0, 1, 0);
    add_vec(0, 0, 0, 0, 3,  1, 1, 0, 1, 1);
    add_vec(0, 0, 0, 0, 3,  1, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 3,  1, 3, 1, 0, 1);
    add_vec(0, 1, 0, 0, 3,  1, 3, 0, 1, 0);
    add_vec(0, 0, 0, 0, 1,  1, 1, 0, 1, 1);
    add_vec(0, 0, 0, 0, 1,  1, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 1,  1, 1, 1, 0, 1);
    enable = 1'b1;
    mode_oneshot = 1'b1;
    div_value = 8'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      div_load = vecs[i].ld; start = vecs[i].st; clear = vecs[i].clr;
      up_down = vecs[i].ud; limit = vecs[i].lim;
      step();
      chk($sformatf("v%0d_tick", i), tick, vecs[i].e_tick);
      chk($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
      chk($sformatf("v%0d_term", i), terminal, vecs[i].e_term);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_clk_div", i), clk_div, vecs[i].e_cd);
    end
    div_load = 1'b0; start = 1'b0; clear = 1'b0;

    // div_load re-phases the prescaler and suppresses the tick of its cycle
    mode_oneshot = 1'b0; up_down = 1'b1; limit = 4'd9;
    do_reset();
    div_load = 1'b1; div_value = 8'd7;
    step();
    chk("ld7_tick", tick, 0);
    div_load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("ld7_wait_tick", tick, 0);
    end
    div_load = 1'b1; div_value = 8'd1;
    step();
    chk("ld1_edge_tick", tick, 0);
    div_load = 1'b0;
    step();
    chk("ld1_c1_tick", tick, 0);
    step();
    chk("ld1_c2_tick", tick, 1);
    step();
    chk("ld1_c3_tick", tick, 0);
    step();
    chk("ld1_c4_tick", tick, 1);
    step();
    chk("ld1_c5_tick", tick, 0);
    div_load = 1'b1; div_value = 8'd2;
    step();
    chk("ld2_suppress_tick", tick, 0);
    div_load = 1'b0;
    wait_tick(n);
    chk("ld2_gap", n, 3);

    // clear wins over div_load; then limit 0 wraps every tick
    do_reset();
    wait_tick(n);
    wait_tick(n);
    chk("pre_clr_count", count, 2);
    clear = 1'b1; div_load = 1'b1; div_value = 8'd0;
    step();
    chk("clr_count", count, 0);
    chk("clr_busy", busy, 0);
    chk("clr_tick", tick, 0);
    clear = 1'b0; div_load = 1'b0; limit = 4'd0;
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      chk("lim0_gap", n, 4);
      chk("lim0_count", count, 0);
      chk("lim0_term", terminal, 1);
    end

    // reset mid-run restores outputs and the default divider
    limit = 4'd9;
    do_reset();
    div_load = 1'b1; div_value = 8'd5;
    step();
    div_load = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      wait_tick(n);
      chk("r6_gap", n, 6);
    end
    chk("r6_count", count, 6);
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    step();
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_term", terminal, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_clk_div", clk_div, 0);
    reset = 1'b0;
    wait_tick(n);
    chk("post_rst_gap", n, 4);
    chk("post_rst_count", count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
